// File: rtl/inst_prefetch_queue_pkg.sv
// Shared RV front-end constants and the fetch-queue entry type.
// Imported by the prefetch queue top and its FIFO.
package inst_prefetch_queue_pkg;

    localparam int XLEN = 32;

    // addi x0,x0,0 -- shown to decode whenever the queue has nothing to offer
    localparam logic [XLEN-1:0] NOP_INST_DEFAULT   = 32'h0000_0013;
    localparam logic [XLEN-1:0] RESET_ADDR_DEFAULT = 32'h0000_0000;
    localparam logic [XLEN-1:0] INST_BYTES         = 32'd4;

    // One buffered fetch: where it came from and what came back
    typedef struct packed {
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] inst;
    } fetch_entry_t;

    localparam int ENTRY_W = 2 * XLEN;

    // Sequential fetch step; wraps modulo 2^32 by construction
    function automatic logic [XLEN-1:0] next_fetch_addr(input logic [XLEN-1:0] addr);
        return addr + INST_BYTES;
    endfunction

endpackage

// File: rtl/inst_prefetch_queue_sync_fifo.sv
// Small synchronous FIFO with first-word fall-through head and a flush.
// Storage is a plain array; the head is read combinationally so a word
// pushed on one edge is visible immediately after it.
module inst_prefetch_queue_sync_fifo #(
    parameter  int DEPTH = 4,
    parameter  int WIDTH = 64,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic [CNT_W-1:0] count,
    output logic             empty,
    output logic             full
);

    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
    logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
    logic [CNT_W-1:0] count_reg, count_next;
    logic             push_en;
    logic             pop_en;
    logic [DEPTH-1:0] wr_sel;

    // Flush beats both push and pop; popping an empty queue is ignored
    assign push_en   = push & ~flush;
    assign pop_en    = pop & ~flush & ~empty;
    assign empty     = (count_reg == '0);
    assign full      = (count_reg == CNT_W'(DEPTH));
    assign count     = count_reg;
    assign head_data = mem_reg[rd_ptr_reg];

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_wr_sel
            assign wr_sel[gi] = push_en & (wr_ptr_reg == PTR_W'(gi));
        end
    endgenerate

    // Entry storage: written at the write pointer, never reset (guarded by count)
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (wr_sel[i]) begin
                mem_reg[i] <= push_data;
            end
        end
    end

    // Pointer and occupancy next-state; pointers wrap naturally at DEPTH
    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        if (flush) begin
            wr_ptr_next = '0;
            rd_ptr_next = '0;
            count_next  = '0;
        end else begin
            if (push_en) begin
                wr_ptr_next = wr_ptr_reg + PTR_W'(1);
            end
            if (pop_en) begin
                rd_ptr_next = rd_ptr_reg + PTR_W'(1);
            end
            case ({push_en, pop_en})
                2'b10:   count_next = count_reg + CNT_W'(1);
                2'b01:   count_next = count_reg - CNT_W'(1);
                default: count_next = count_reg;
            endcase
        end
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
        end
    end

    // Overwriting the oldest entry means the producer's throttle is broken
    a_no_push_when_full: assert property (@(posedge clk) disable iff (!rst_n) !(push_en && full));

endmodule

// File: rtl/inst_prefetch_queue.sv
// Instruction prefetch queue: issues sequential fetches over a req/gnt/rvalid
// memory port with one request in flight, buffers the returned words and
// presents the oldest to decode. Jumps flush the queue and retarget fetch;
// a response already in flight at the jump is discarded on arrival.
module inst_prefetch_queue
    import inst_prefetch_queue_pkg::*;
#(
    parameter int              DEPTH      = 4,
    parameter logic [XLEN-1:0] RESET_ADDR = RESET_ADDR_DEFAULT,
    parameter logic [XLEN-1:0] NOP_INST   = NOP_INST_DEFAULT
) (
    input  logic            sys_clk,
    input  logic            sys_rst_n,
    input  logic            jump_en,
    input  logic [XLEN-1:0] jump_addr,
    input  logic            hold_en,
    output logic            mem_req,
    output logic [XLEN-1:0] mem_addr,
    input  logic            mem_gnt,
    input  logic            mem_rvalid,
    input  logic [XLEN-1:0] mem_rdata,
    output logic [XLEN-1:0] inst,
    output logic [XLEN-1:0] inst_addr,
    output logic            inst_valid
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int OCC_W = CNT_W + 1;

    logic [XLEN-1:0]  fetch_pc_reg, fetch_pc_next;
    logic [XLEN-1:0]  tag_addr_reg, tag_addr_next;
    logic             outstanding_reg, outstanding_next;
    logic             discard_reg, discard_next;

    logic             outstanding_after_rvalid;
    logic [OCC_W-1:0] occupancy;
    logic             grant;
    logic             push;
    logic             pop;

    fetch_entry_t     push_entry;
    fetch_entry_t     head_entry;
    logic [CNT_W-1:0] fifo_count;
    logic             fifo_empty;
    logic             fifo_full;

    // A response retires the in-flight request in the same cycle it arrives
    assign outstanding_after_rvalid = outstanding_reg & ~mem_rvalid;

    // Responses are buffered unless marked stale or overtaken by a jump
    assign push = mem_rvalid & ~discard_reg & ~jump_en;
    assign pop  = ~fifo_empty & ~hold_en & ~jump_en;

    // Slots already spoken for: buffered words, the word landing this cycle,
    // and the request still in flight. Pops are not credited so that a new
    // request never depends on the stall input.
    assign occupancy = OCC_W'(fifo_count)
                     + OCC_W'(push)
                     + OCC_W'(outstanding_after_rvalid);

    // Back-to-back issue is allowed: a same-cycle response frees the port
    assign mem_req = sys_rst_n
                   & ~jump_en
                   & (~outstanding_reg | mem_rvalid)
                   & ~fifo_full
                   & (occupancy < OCC_W'(DEPTH));
    assign mem_addr = fetch_pc_reg;
    assign grant    = mem_req & mem_gnt;

    assign push_entry = '{addr: tag_addr_reg, inst: mem_rdata};

    inst_prefetch_queue_sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk       (sys_clk),
        .rst_n     (sys_rst_n),
        .flush     (jump_en),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .head_data (head_entry),
        .count     (fifo_count),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    // Empty queue shows a NOP at address 0 so decode never sees stale data
    assign inst_valid = ~fifo_empty;
    assign inst       = fifo_empty ? NOP_INST : head_entry.inst;
    assign inst_addr  = fifo_empty ? '0 : head_entry.addr;

    // Fetch control next-state: jump outranks grant; responses always retire
    always_comb begin
        fetch_pc_next    = fetch_pc_reg;
        tag_addr_next    = tag_addr_reg;
        outstanding_next = outstanding_reg;
        discard_next     = discard_reg;

        if (mem_rvalid) begin
            outstanding_next = 1'b0;
            discard_next     = 1'b0;
        end

        if (jump_en) begin
            fetch_pc_next = jump_addr;
            // Only a response still to come needs to be thrown away later;
            // one arriving right now is already blocked from the push.
            if (outstanding_reg & ~mem_rvalid) begin
                discard_next = 1'b1;
            end
        end else if (grant) begin
            fetch_pc_next    = next_fetch_addr(fetch_pc_reg);
            tag_addr_next    = fetch_pc_reg;
            outstanding_next = 1'b1;
        end
    end

    // Fetch control registers
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            fetch_pc_reg    <= RESET_ADDR;
            tag_addr_reg    <= '0;
            outstanding_reg <= 1'b0;
            discard_reg     <= 1'b0;
        end else begin
            fetch_pc_reg    <= fetch_pc_next;
            tag_addr_reg    <= tag_addr_next;
            outstanding_reg <= outstanding_next;
            discard_reg     <= discard_next;
        end
    end

endmodule

// File: tb/tb_inst_prefetch_queue.sv
// Directed bench for inst_prefetch_queue with a behavioural memory responder.
module tb_inst_prefetch_queue;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        sys_clk;
    logic        sys_rst_n;
    logic        jump_en;
    logic [31:0] jump_addr;
    logic        hold_en;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic [31:0] inst;
    logic [31:0] inst_addr;
    logic        inst_valid;

    int total = 0;
    int bad   = 0;

    // responder configuration and state
    int          lat_cfg   = 1;
    bit          lat_rand  = 0;
    bit          gnt_rand  = 0;
    bit          pend      = 0;
    logic [31:0] pend_addr = '0;
    int          cnt       = 0;
    int          grant_cnt = 0;

    logic [31:0] exp_addr;
    int          npops;

    inst_prefetch_queue dut (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .jump_en    (jump_en),
        .jump_addr  (jump_addr),
        .hold_en    (hold_en),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .inst       (inst),
        .inst_addr  (inst_addr),
        .inst_valid (inst_valid)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    function automatic logic [31:0] rom(input logic [31:0] a);
        if (a == 32'h0) return 32'h0050_0093;
        return {a[31:2] ^ 30'h2A5A_5A5A, 2'b11};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // inputs change on the falling edge; outputs are checked 3 time units later
    task automatic tick();
        @(negedge sys_clk);
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic apply_reset();
        tick();
        sys_rst_n = 1'b0;
        jump_en   = 1'b0;
        hold_en   = 1'b0;
        jump_addr = '0;
        lat_cfg   = 1;
        lat_rand  = 0;
        gnt_rand  = 0;
        tick();
        settle();
    endtask

    // Memory responder: one response per grant after lat cycles; a reset
    // throws away whatever was in flight.
    initial begin
        mem_gnt    = 1'b1;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        forever begin
            @(negedge sys_clk);
            #1;
            mem_rvalid = 1'b0;
            mem_rdata  = '0;
            if (!sys_rst_n) begin
                pend = 0;
            end else if (pend) begin
                if (cnt == 0) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = rom(pend_addr);
                    pend       = 0;
                end else begin
                    cnt--;
                end
            end
            mem_gnt = gnt_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            if (sys_rst_n && mem_req && mem_gnt) begin
                chk1("one_in_flight", pend, 1'b0);
                pend      = 1;
                pend_addr = mem_addr;
                cnt       = (lat_rand ? int'($urandom_range(1, 5)) : lat_cfg) - 1;
                grant_cnt++;
            end
        end
    end

    initial begin
        sys_rst_n = 1'b0;
        jump_en   = 1'b0;
        jump_addr = '0;
        hold_en   = 1'b0;
        repeat (2) tick();
        settle();

        // reset state
        chk1("rst_mem_req", mem_req, 1'b0);
        chk("rst_inst", inst, NOP);
        chk("rst_inst_addr", inst_addr, 32'h0);
        chk1("rst_inst_valid", inst_valid, 1'b0);

        // sequential fetch, 1-cycle memory, always granted
        tick(); sys_rst_n = 1'b1; settle();
        for (int i = 0; i < 7; i++) begin
            if (i > 0) begin tick(); settle(); end
            chk1("t1_req", mem_req, 1'b1);
            chk("t1_mem_addr", mem_addr, 32'(4 * i));
            if (i < 2) begin
                chk1("t1_valid_early", inst_valid, 1'b0);
                chk("t1_inst_nop", inst, NOP);
            end else begin
                chk1("t1_valid", inst_valid, 1'b1);
                chk("t1_inst_addr", inst_addr, 32'(4 * (i - 2)));
                chk("t1_inst", inst, rom(32'(4 * (i - 2))));
            end
        end

        // reset in the middle of a transaction; stale response must not appear
        apply_reset();
        chk1("mid_rst_valid", inst_valid, 1'b0);
        chk1("mid_rst_req", mem_req, 1'b0);

        // hold for 10 cycles: exactly DEPTH grants, head stays at 0
        tick(); sys_rst_n = 1'b1; hold_en = 1'b1; grant_cnt = 0; settle();
        for (int i = 0; i < 10; i++) begin
            if (i > 0) begin tick(); settle(); end
            if (i >= 2) begin
                chk("t3_head_addr", inst_addr, 32'h0);
                chk("t3_head_inst", inst, rom(32'h0));
            end
            if (i >= 4) chk1("t3_req_off", mem_req, 1'b0);
        end
        chk("t3_grants", grant_cnt, 32'd4);
        for (int i = 0; i < 5; i++) begin
            tick(); hold_en = 1'b0; settle();
            chk1("t3_drain_valid", inst_valid, 1'b1);
            chk("t3_drain_addr", inst_addr, 32'(4 * i));
        end

        // jump while the request to 0x8 is in flight with 3-cycle latency
        apply_reset();
        tick(); sys_rst_n = 1'b1; hold_en = 1'b1; settle();
        tick(); settle();
        tick(); lat_cfg = 3; settle();
        chk1("t4_req8", mem_req, 1'b1);
        chk("t4_addr8", mem_addr, 32'h8);
        tick(); lat_cfg = 1; hold_en = 1'b0; jump_en = 1'b1; jump_addr = 32'h100; settle();
        chk1("t4_jump_req", mem_req, 1'b0);
        tick(); jump_en = 1'b0; settle();
        chk1("t4_wait_req", mem_req, 1'b0);
        chk1("t4_flushed", inst_valid, 1'b0);
        tick(); settle();
        chk1("t4_refetch_req", mem_req, 1'b1);
        chk("t4_refetch_addr", mem_addr, 32'h100);
        chk1("t4_stale_dropped", inst_valid, 1'b0);
        tick(); settle();
        chk1("t4_still_empty", inst_valid, 1'b0);
        tick(); settle();
        chk1("t4_valid", inst_valid, 1'b1);
        chk("t4_inst_addr", inst_addr, 32'h100);
        chk("t4_inst", inst, rom(32'h100));

        // jump coinciding with a response and a pop
        apply_reset();
        tick(); sys_rst_n = 1'b1; settle();
        tick(); settle();
        tick(); jump_en = 1'b1; jump_addr = 32'h200; settle();
        chk1("t5_head_before", inst_valid, 1'b1);
        chk1("t5_jump_req", mem_req, 1'b0);
        tick(); jump_en = 1'b0; settle();
        chk1("t5_empty", inst_valid, 1'b0);
        chk1("t5_discard", dut.discard_reg, 1'b0);
        chk1("t5_req", mem_req, 1'b1);
        chk("t5_addr", mem_addr, 32'h200);
        tick(); settle();
        chk1("t5_wait", inst_valid, 1'b0);
        tick(); settle();
        chk1("t5_valid", inst_valid, 1'b1);
        chk("t5_inst_addr", inst_addr, 32'h200);

        // fetch address wraps past the top of the address space
        apply_reset();
        tick(); sys_rst_n = 1'b1; hold_en = 1'b1; jump_en = 1'b1; jump_addr = 32'hFFFF_FFFC; settle();
        chk1("t7_jump_req", mem_req, 1'b0);
        tick(); jump_en = 1'b0; settle();
        chk1("t7_req", mem_req, 1'b1);
        chk("t7_addr_top", mem_addr, 32'hFFFF_FFFC);
        tick(); settle();
        chk("t7_addr_wrap", mem_addr, 32'h0);
        tick(); settle();
        chk("t7_head", inst_addr, 32'hFFFF_FFFC);

        // random grant, latency, hold and jumps
        apply_reset();
        lat_rand = 1;
        gnt_rand = 1;
        exp_addr = 32'h0;
        npops    = 0;
        tick(); sys_rst_n = 1'b1; settle();
        for (int i = 0; i < 1000; i++) begin
            if (i > 0) begin
                tick();
                hold_en   = ($urandom_range(0, 3) == 0);
                jump_en   = ($urandom_range(0, 29) == 0);
                jump_addr = {20'h0, 10'($urandom_range(0, 1023)), 2'b00};
                settle();
            end
            if (inst_valid) begin
                chk("t6_seq_addr", inst_addr, exp_addr);
                chk("t6_rom_data", inst, rom(inst_addr));
            end
            if (jump_en) begin
                $display("jump to %h", jump_addr);
                exp_addr = jump_addr;
            end else if (inst_valid && !hold_en) begin
                $display("pop addr=%h inst=%h", inst_addr, inst);
                exp_addr = exp_addr + 32'd4;
                npops++;
            end
        end
        chk1("t6_activity", npops > 50, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/inst_prefetch_queue.md
Name: inst_prefetch_queue

Overview:
- Fetch front-end between program_counter and if_id; replaces direct combinational ROM reads.
- Issues sequential fetch requests to an instruction memory port with a req/gnt/rvalid handshake and variable latency.
- Buffers returned words in a small FIFO and presents the head to if_id.
- Honours jump redirects from execution (flush + refetch) and stalls on hold_en.

Parameters:
- DEPTH, 4, FIFO entries (power of two, >=2).
- RESET_ADDR, 32'h0000_0000, first fetch address after reset.
- NOP_INST, 32'h0000_0013, word presented when the queue is empty (addi x0,x0,0).

Ports:
- sys_clk  in  1  clock; all state updates on rising edge.
- sys_rst_n  in  1  asynchronous active-low reset.
- jump_en  in  1  redirect request from execution.
- jump_addr  in  32  redirect target; word aligned.
- hold_en  in  1  pipeline stall; head must not be popped.
- mem_req  out  1  fetch request valid.
- mem_addr  out  32  fetch address; equals fetch_pc.
- mem_gnt  in  1  request accepted this cycle (handshake = mem_req & mem_gnt).
- mem_rvalid  in  1  response valid; earliest one cycle after grant.
- mem_rdata  in  32  response instruction word.
- inst  out  32  head instruction, or NOP_INST when empty.
- inst_addr  out  32  address of head instruction, 0 when empty.
- inst_valid  out  1  queue non-empty.

Behaviour:
- Reset (async, sys_rst_n=0):
  - fetch_pc=RESET_ADDR; FIFO empty; outstanding=0; discard=0.
  - Outputs: mem_req=0, inst=NOP_INST, inst_addr=0, inst_valid=0.
- Outstanding limit: at most one request in flight. The outstanding flag sets on grant and clears on mem_rvalid.
- mem_req = !jump_en & (!outstanding | mem_rvalid) & (count + outstanding_after_rvalid < DEPTH), where outstanding_after_rvalid is the outstanding flag after any same-cycle response retires it.
  - mem_req depends combinationally on mem_rvalid (back-to-back issue).
- On grant: fetch_pc += 4 (wraps modulo 2^32). The granted address is stored in a tag register for pairing with the response.
- On mem_rvalid with discard=0: push {mem_rdata, tag address} into the FIFO.
- On mem_rvalid with discard=1: drop the data and clear discard.
- Pop: occurs when inst_valid & !hold_en & !jump_en. Pointers and count advance.
  - Simultaneous push and pop: count unchanged.
  - Full is unreachable because of the request throttle. A push into a full queue is an assertion failure.
- Jump (jump_en=1): highest priority over push, pop and grant.
  - fetch_pc <= jump_addr.
  - FIFO emptied (count=0, pointers reset).
  - mem_req forced 0 that cycle.
  - If outstanding & !mem_rvalid: set discard=1. Any same-cycle response is dropped.
  - First request to jump_addr is issued in the next cycle at earliest.
- Latency: grant at cycle N, rvalid at N+k, instruction visible on inst/inst_valid at N+k+1.
- hold_en with jump_en: jump wins (flush).
- hold_en alone: queue still fills up to DEPTH, then requests stop.
- Reset asserted mid-transaction: all state is cleared. The bench must not return the stale response after reset.
- Width rule: count is $clog2(DEPTH)+1 bits; pointers are $clog2(DEPTH) bits and wrap naturally.

Decomposition:
- Shared package (rv_pkg): NOP_INST constant, XLEN=32, RESET_ADDR default.
- One natural sub-module: sync_fifo (DEPTH x 64-bit {addr,inst}; push/pop/count/empty/full), reusable elsewhere.
- The request/discard control stays in the top module.

Test Plan:
- Reset release, memory with 1-cycle latency and mem_gnt=1:
  - mem_addr sequence 0,4,8,... on consecutive request cycles.
  - First inst_valid=1 two cycles after the first grant, with inst_addr=0.
- Empty queue, ROM word 32'h00500093 at addr 0: inst=32'h00000013 and inst_valid=0 until the response, then inst=32'h00500093.
- hold_en=1 for 10 cycles with DEPTH=4:
  - Exactly 4 grants, then mem_req=0.
  - The head stays at addr 0 throughout.
  - Releasing hold pops one entry per cycle: addrs 0,4,8,12.
- jump_en with jump_addr=32'h100 while a request to 0x8 is outstanding (response 3 cycles later):
  - The 0x8 response is dropped.
  - The next request issued is to 0x100.
  - The first valid inst_addr is 0x100.
- jump_en in the same cycle as mem_rvalid and a pop: the queue is empty next cycle, the data is not pushed, and discard stays 0.
- Random mem_gnt and 1-5 cycle latency, 1000 cycles, random jumps: every presented inst equals ROM[inst_addr], and addresses are sequential between jumps.
